// File: rtl/fifo_pkg.sv
// Width helpers shared by the synchronous FIFO family.
// The pointer carries one wrap bit above the index; the count must reach DEPTH+1.
package fifo_pkg;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage

// File: rtl/sync_fifo_out_reg.sv
// One-entry valid/ready pipeline register.
// It refills in the same cycle its current entry is taken.
module sync_fifo_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/sync_fifo_hs.sv
// Single-clock circular FIFO with valid/ready on both sides, occupancy count,
// almost-full/almost-empty flags and an optional registered output stage.
module sync_fifo_hs
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int REG_OUT   = 0,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [fifo_cnt_w(DEPTH)-1:0] count,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = fifo_ptr_w(DEPTH);
    localparam int CNT_W = fifo_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_LVL = CNT_W'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             mem_empty;
    logic             mem_full;
    logic             push;
    logic             pop;
    logic             mem_pop;
    logic [WIDTH-1:0] head_data;

    assign mem_empty = (rd_ptr == wr_ptr);
    assign mem_full  = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) &&
                       (rd_ptr[IDX_W] != wr_ptr[IDX_W]);
    assign head_data = mem[rd_ptr[IDX_W-1:0]];

    // in_ready depends on registers only, so a pop never frees room for a same-cycle push
    assign in_ready  = !mem_full;
    assign push      = in_valid && in_ready && !rst;
    assign pop       = out_valid && out_ready;

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic load_ready;

            sync_fifo_out_reg #(
                .WIDTH(WIDTH)
            ) u_out_reg (
                .clk      (clk),
                .rst      (rst),
                .in_data  (head_data),
                .in_valid (!mem_empty),
                .in_ready (load_ready),
                .out_data (out_data),
                .out_valid(out_valid),
                .out_ready(out_ready)
            );

            assign mem_pop = !mem_empty && load_ready;
        end else begin : g_comb_out
            assign out_valid = !mem_empty;
            assign out_data  = head_data;
            assign mem_pop   = pop;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[IDX_W-1:0]] <= in_data;
        end
    end

    // count tracks external handshakes only; memory-to-register moves leave it unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (mem_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

endmodule

// File: tb/tb_sync_fifo_hs.sv
// Bench for sync_fifo_hs: drives a REG_OUT=0 and a REG_OUT=1 instance with shared stimulus,
// checks both against queue models every cycle plus hand-computed directed expectations.
module tb_sync_fifo_hs;

    localparam int DEPTH     = 8;
    localparam int AF_THRESH = 6;
    localparam int AE_THRESH = 1;
    localparam int CNT_W     = $clog2(DEPTH) + 2;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic [7:0]       in_data   = 8'h00;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;

    logic             in_ready0, in_ready1;
    logic             out_valid0, out_valid1;
    logic [7:0]       out_data0, out_data1;
    logic [CNT_W-1:0] count0, count1;
    logic             af0, af1, ae0, ae1;

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_hs #(
        .DEPTH(DEPTH), .WIDTH(8), .REG_OUT(0), .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
    ) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .count(count0), .almost_full(af0), .almost_empty(ae0)
    );

    sync_fifo_hs #(
        .DEPTH(DEPTH), .WIDTH(8), .REG_OUT(1), .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
    ) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .count(count1), .almost_full(af1), .almost_empty(ae1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Model: q0/q1 hold every stored entry in order; reg_full1 says whether q1's head sits in the output register
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         reg_full1 = 1'b0;
    int         m_mem1;
    bit         m_push, m_pop, m_load;

    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            reg_full1 = 1'b0;
        end else begin
            m_push = in_valid && (q0.size() < DEPTH);
            m_pop  = out_ready && (q0.size() > 0);
            if (m_pop)  q0.delete(0);
            if (m_push) q0.push_back(in_data);

            m_mem1 = q1.size() - int'(reg_full1);
            m_push = in_valid && (m_mem1 < DEPTH);
            m_pop  = out_ready && reg_full1;
            m_load = (!reg_full1 || m_pop) && (m_mem1 > 0);
            if (m_pop)  q1.delete(0);
            if (m_push) q1.push_back(in_data);
            reg_full1 = m_load ? 1'b1 : (m_pop ? 1'b0 : reg_full1);
        end
    end

    int         c_size0, c_size1, c_mem1;
    bit         hold0 = 1'b0, hold1 = 1'b0;
    logic [7:0] hold_exp0, hold_exp1;

    always @(negedge clk) begin
        if (checking) begin
            c_size0 = q0.size();
            c_size1 = q1.size();
            c_mem1  = c_size1 - int'(reg_full1);

            checkOutput("in_ready0", 32'(in_ready0), 32'(c_size0 < DEPTH));
            checkOutput("out_valid0", 32'(out_valid0), 32'(c_size0 > 0));
            if (c_size0 > 0) checkOutput("out_data0", 32'(out_data0), 32'(q0[0]));
            checkOutput("count0", 32'(count0), 32'(c_size0));
            checkOutput("almost_full0", 32'(af0), 32'(c_size0 >= AF_THRESH));
            checkOutput("almost_empty0", 32'(ae0), 32'(c_size0 <= AE_THRESH));

            checkOutput("in_ready1", 32'(in_ready1), 32'(c_mem1 < DEPTH));
            checkOutput("out_valid1", 32'(out_valid1), 32'(reg_full1));
            if (reg_full1) checkOutput("out_data1", 32'(out_data1), 32'(q1[0]));
            checkOutput("count1", 32'(count1), 32'(c_size1));
            checkOutput("almost_full1", 32'(af1), 32'(c_size1 >= AF_THRESH));
            checkOutput("almost_empty1", 32'(ae1), 32'(c_size1 <= AE_THRESH));

            if (hold0) begin
                checkOutput("hold_valid0", 32'(out_valid0), 32'd1);
                checkOutput("hold_data0", 32'(out_data0), 32'(hold_exp0));
            end
            if (hold1) begin
                checkOutput("hold_valid1", 32'(out_valid1), 32'd1);
                checkOutput("hold_data1", 32'(out_data1), 32'(hold_exp1));
            end

            hold0     = (c_size0 > 0) && !out_ready && !rst;
            hold_exp0 = (c_size0 > 0) ? q0[0] : 8'h00;
            hold1     = reg_full1 && !out_ready && !rst;
            hold_exp1 = reg_full1 ? q1[0] : 8'h00;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // reset state
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rst_in_ready0", 32'(in_ready0), 32'd1);
        checkOutput("rst_in_ready1", 32'(in_ready1), 32'd1);
        checkOutput("rst_out_valid0", 32'(out_valid0), 32'd0);
        checkOutput("rst_out_valid1", 32'(out_valid1), 32'd0);
        checkOutput("rst_count0", 32'(count0), 32'd0);
        checkOutput("rst_count1", 32'(count1), 32'd0);
        checkOutput("rst_af0", 32'(af0), 32'd0);
        checkOutput("rst_ae1", 32'(ae1), 32'd1);
        checkOutput("rst_out_data1", 32'(out_data1), 32'd0);
        rst      = 1'b0;
        checking = 1'b1;

        // fill with 0x01..0x08, consumer stalled
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 8'(k), 1'b0);
            checkOutput("t1_count0", 32'(count0), 32'(k));
            checkOutput("t1_in_ready0", 32'(in_ready0), 32'(k < 8));
            checkOutput("t1_af0", 32'(af0), 32'(k >= 6));
            checkOutput("t1_ae0", 32'(ae0), 32'(k <= 1));
            checkOutput("t1_out_valid1", 32'(out_valid1), 32'(k >= 2));
            checkOutput("t1_count1", 32'(count1), 32'(k));
        end
        applyStimulus(1'b1, 8'h09, 1'b0);
        checkOutput("t1_9th_count0", 32'(count0), 32'd8);
        checkOutput("t1_9th_count1", 32'(count1), 32'd9);
        checkOutput("t1_9th_in_ready1", 32'(in_ready1), 32'd0);
        applyStimulus(1'b1, 8'h0A, 1'b0);
        checkOutput("t1_10th_count0", 32'(count0), 32'd8);
        checkOutput("t1_10th_count1", 32'(count1), 32'd9);

        // drain in order
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) checkOutput("t2_data0", 32'(out_data0), 32'(i));
            checkOutput("t2_data1", 32'(out_data1), 32'(i));
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("t2_out_valid0", 32'(out_valid0), 32'd0);
        checkOutput("t2_out_valid1", 32'(out_valid1), 32'd0);
        checkOutput("t2_count0", 32'(count0), 32'd0);
        checkOutput("t2_ae0", 32'(ae0), 32'd1);

        // steady streaming at occupancy 3 across pointer wraps
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'(16 + k), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int j = 0; j < 20; j++) begin
            checkOutput("t3_data0", 32'(out_data0), 32'(16 + j));
            checkOutput("t3_data1", 32'(out_data1), 32'(16 + j));
            applyStimulus(1'b1, 8'(19 + j), 1'b1);
            checkOutput("t3_count0", 32'(count0), 32'd3);
            checkOutput("t3_count1", 32'(count1), 32'd3);
        end
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3_drain_count0", 32'(count0), 32'd0);
        checkOutput("t3_drain_count1", 32'(count1), 32'd0);

        // random valid/ready traffic, checked by the models
        for (int c = 0; c < 1000; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (12) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t4_count0", 32'(count0), 32'd0);
        checkOutput("t4_count1", 32'(count1), 32'd0);

        // full plus simultaneous push/pop: only the pop happens
        for (int k = 0; k < 9; k++) applyStimulus(1'b1, 8'(32 + k), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t5_full_count0", 32'(count0), 32'd8);
        checkOutput("t5_full_count1", 32'(count1), 32'd9);
        checkOutput("t5_full_in_ready0", 32'(in_ready0), 32'd0);
        checkOutput("t5_head0", 32'(out_data0), 32'h20);
        checkOutput("t5_head1", 32'(out_data1), 32'h20);
        applyStimulus(1'b1, 8'hAA, 1'b1);
        checkOutput("t5_count0", 32'(count0), 32'd7);
        checkOutput("t5_count1", 32'(count1), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            if (i <= 7) checkOutput("t5_data0", 32'(out_data0), 32'(32 + i));
            checkOutput("t5_data1", 32'(out_data1), 32'(32 + i));
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("t5_drain_count0", 32'(count0), 32'd0);
        checkOutput("t5_drain_count1", 32'(count1), 32'd0);

        // reset mid-stream
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 8'(48 + k), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t6_pre_count0", 32'(count0), 32'd5);
        checkOutput("t6_pre_count1", 32'(count1), 32'd5);
        rst = 1'b1;
        applyStimulus(1'b1, 8'h35, 1'b1);
        rst = 1'b0;
        checkOutput("t6_count0", 32'(count0), 32'd0);
        checkOutput("t6_count1", 32'(count1), 32'd0);
        checkOutput("t6_out_valid0", 32'(out_valid0), 32'd0);
        checkOutput("t6_out_valid1", 32'(out_valid1), 32'd0);
        checkOutput("t6_in_ready0", 32'(in_ready0), 32'd1);
        checkOutput("t6_in_ready1", 32'(in_ready1), 32'd1);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkOutput("t6_push_valid0", 32'(out_valid0), 32'd1);
        checkOutput("t6_push_data0", 32'(out_data0), 32'h5A);
        checkOutput("t6_push_valid1", 32'(out_valid1), 32'd0);
        checkOutput("t6_push_count1", 32'(count1), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t6_late_valid1", 32'(out_valid1), 32'd1);
        checkOutput("t6_late_data1", 32'(out_data1), 32'h5A);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t6_end_count0", 32'(count0), 32'd0);
        checkOutput("t6_end_count1", 32'(count1), 32'd0);

        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
